// File: rtl/md_sched_if.sv
// md_sched_if: E-stage mult/div request bus plus the HI/LO and busy/stall results.
interface md_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, md_op, a, b, cancel, input busy, stall_req, hi, lo);
  modport slave  (input start, md_op, a, b, cancel, output busy, stall_req, hi, lo);
endinterface

// File: rtl/md_sched.sv
// md_sched: multi-cycle mult/div scheduler owning the HI/LO registers and the pipeline stall request.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_sched_if.slave   bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [31:0]   r_a, r_b, r_hi, r_lo, w_a, w_b, w_hi, w_lo;
  logic          r_sgn, w_sgn, w_acc, w_busy;
  logic [63:0]   w_prod;
  logic [31:0]   w_ma, w_mb, w_q, w_r, w_quo, w_rem;
  assign w_busy = r_state != S_IDLE;
  assign w_acc  = bus.start && !bus.cancel && r_state == S_IDLE;
  assign w_prod = r_sgn ? $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b})
                        : {32'd0, r_a} * {32'd0, r_b};
  // signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow
  assign w_ma  = (r_sgn && r_a[31]) ? -r_a : r_a;
  assign w_mb  = (r_sgn && r_b[31]) ? -r_b : r_b;
  assign w_q   = w_mb == '0 ? '0 : w_ma / w_mb;
  assign w_r   = w_mb == '0 ? '0 : w_ma % w_mb;
  assign w_quo = (r_sgn && (r_a[31] ^ r_b[31])) ? -w_q : w_q;
  assign w_rem = (r_sgn && r_a[31]) ? -w_r : w_r;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_a     = r_a;
    w_b     = r_b;
    w_sgn   = r_sgn;
    w_hi    = r_hi;
    w_lo    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_acc && !bus.md_op[2]) begin
          w_state = bus.md_op[1] ? S_DIV : S_MUL;
          w_cnt   = bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          w_a     = bus.a;
          w_b     = bus.b;
          w_sgn   = !bus.md_op[0];
        end
        else if (w_acc && bus.md_op == 3'b100) w_hi = bus.a;
        else if (w_acc && bus.md_op == 3'b101) w_lo = bus.a;
      end
      S_MUL, S_DIV: begin
        w_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state = S_IDLE;
          if (r_state == S_MUL) {w_hi, w_lo} = w_prod;
          else if (r_b != '0) begin
            w_hi = w_rem;
            w_lo = w_quo;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_a     <= w_a;
      r_b     <= w_b;
      r_sgn   <= w_sgn;
      r_hi    <= w_hi;
      r_lo    <= w_lo;
    end
  end
  assign bus.busy      = w_busy;
  assign bus.stall_req = w_busy || (bus.start && !bus.md_op[2]);
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration of mult/multu, in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration of div/divu, in cycles.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1: E-stage mult/div/move-to-HI/LO instruction present this cycle.
REQ-006 SHALL have port md_op  in  3: operation select. 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op.
REQ-007 SHALL have port a  in  32: rs operand, forwarded.
REQ-008 SHALL have port b  in  32: rt operand, forwarded.
REQ-009 SHALL have port cancel  in  1: interrupt/exception flush request from the M stage.
REQ-010 SHALL have port busy  out  1: multi-cycle operation in progress.
REQ-011 SHALL have port stall_req  out  1: request to stall the D/E stages.
REQ-012 SHALL have port hi  out  32: HI register.
REQ-013 SHALL have port lo  out  32: LO register.

Function
REQ-014 SHALL implement a state machine with states IDLE, MUL, DIV.
REQ-015 SHALL accept start only in IDLE with cancel=0. Start in MUL/DIV, or with cancel=1, SHALL be ignored with no state, counter, or hi/lo change.
REQ-016 On an accepted mult/multu, SHALL latch a/b, load the counter with MULT_CYCLES, and enter MUL at the same edge.
REQ-017 On an accepted div/divu, SHALL latch a/b, load the counter with DIV_CYCLES, and enter DIV at the same edge.
REQ-018 On an accepted mthi/mtlo, SHALL write a into hi/lo respectively at that edge, stay in IDLE, and not assert busy.
REQ-019 SHALL treat md_op 110/111 as a no-op: no state change.
REQ-020 SHALL set busy=1 exactly when the state is MUL or DIV, registered, for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) after the accepting edge.
REQ-021 SHALL decrement the counter once per cycle in MUL/DIV.
REQ-022 At the edge where the counter reaches 1, SHALL write hi/lo, return to IDLE, and clear busy together.
REQ-023 mult SHALL produce a signed 64-bit product, {hi,lo} = a*b.
REQ-024 multu SHALL produce an unsigned 64-bit product, {hi,lo} = a*b.
REQ-025 div SHALL produce lo = signed quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-026 divu SHALL produce lo = unsigned quotient and hi = unsigned remainder.
REQ-027 For div/divu with latched b=0, SHALL leave hi and lo unchanged at completion, while still spending the full DIV_CYCLES busy.
REQ-028 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-029 SHALL compute results only from the operands latched at accept; a/b changes while busy SHALL have no effect.
REQ-030 cancel while busy SHALL be ignored: the operation is committed and completes normally.
REQ-031 SHALL drive stall_req = busy OR (start AND md_op in {000..011}), combinationally, so that the accepting cycle also stalls.
REQ-032 SHALL deassert stall_req in the cycle after completion, provided start is low or start carries a move/no-op.
REQ-033 Back-to-back operation: a start presented in the first IDLE cycle after completion SHALL be accepted.

Reset
REQ-034 While reset=0, SHALL asynchronously force state IDLE, counter 0, busy 0, hi 0, lo 0, and the latched operands 0.
REQ-035 reset asserted mid-operation SHALL abort it: no hi/lo write, and busy=0 immediately.
REQ-036 After reset deasserts, the first rising edge SHALL accept start normally.

Verification
REQ-037 Reset release, then start with mult, a=0xFFFFFFFE, b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0.
REQ-038 Start with multu, a=0xFFFFFFFF, b=2 -> after 5 cycles, hi=1, lo=0xFFFFFFFE.
REQ-039 Start with div, a=0xFFFFFFF9 (-7), b=2 -> busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-040 Load hi=0x12345678 via mthi, then divu with b=0 -> after 10 busy cycles, hi=0x12345678 and lo unchanged.
REQ-041 Start with mult while cancel=1 -> busy stays 0, hi/lo unchanged, and stall_req=1 only in that cycle.
REQ-042 Two cases: (a) start div, pulse cancel at cycle 3 -> completion at cycle 10 as normal; (b) start div, drive reset=0 at cycle 4 -> busy=0, hi=lo=0 at once.
